// File: rtl/wb_write_arbiter.sv
// Serializes ALU results and load completions onto the register file's single write port.
// Define WB_SCOREBOARD_EN to build the per-register outstanding-load mask on `pending`.
module wb_write_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wb_en,
    input  logic [3:0]  alu_dest,
    input  logic [31:0] alu_result,
    input  logic        ld_start,
    input  logic [3:0]  ld_dest,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        writeBackEn,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_WB,
    output logic        freeze,
    output logic        ld_busy,
    output logic [15:0] pending
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  ld_tag_reg, ld_tag_next;
    logic        hold_v_reg, hold_v_next;
    logic [3:0]  hold_dest_reg, hold_dest_next;
    logic [31:0] hold_data_reg, hold_data_next;
    logic        wb_en_reg, wb_en_next;
    logic [3:0]  dest_reg, dest_next;
    logic [31:0] result_reg, result_next;

    logic ld_done;
    logic alu_accept;

    assign ld_done    = (state_reg == ST_WAIT) && mem_ready;
    // While a result is parked, the upstream stage is frozen and will re-present it.
    assign alu_accept = alu_wb_en && !hold_v_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ld_tag_reg    <= 4'd0;
            hold_v_reg    <= 1'b0;
            hold_dest_reg <= 4'd0;
            hold_data_reg <= 32'd0;
            wb_en_reg     <= 1'b0;
            dest_reg      <= 4'd0;
            result_reg    <= 32'd0;
        end else begin
            state_reg     <= state_next;
            ld_tag_reg    <= ld_tag_next;
            hold_v_reg    <= hold_v_next;
            hold_dest_reg <= hold_dest_next;
            hold_data_reg <= hold_data_next;
            wb_en_reg     <= wb_en_next;
            dest_reg      <= dest_next;
            result_reg    <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ld_tag_next = ld_tag_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ld_start) begin
                    state_next  = ST_WAIT;
                    ld_tag_next = ld_dest;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    if (ld_start) begin
                        ld_tag_next = ld_dest;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Load data goes first so a same-register ALU result (younger) lands last.
    always_comb begin
        wb_en_next     = 1'b0;
        dest_next      = dest_reg;
        result_next    = result_reg;
        hold_v_next    = hold_v_reg;
        hold_dest_next = hold_dest_reg;
        hold_data_next = hold_data_reg;
        if (ld_done) begin
            wb_en_next  = 1'b1;
            dest_next   = ld_tag_reg;
            result_next = mem_rdata;
            if (alu_accept) begin
                hold_v_next    = 1'b1;
                hold_dest_next = alu_dest;
                hold_data_next = alu_result;
            end
        end else if (hold_v_reg) begin
            wb_en_next  = 1'b1;
            dest_next   = hold_dest_reg;
            result_next = hold_data_reg;
            hold_v_next = 1'b0;
        end else if (alu_wb_en) begin
            wb_en_next  = 1'b1;
            dest_next   = alu_dest;
            result_next = alu_result;
        end
    end

    assign writeBackEn = wb_en_reg;
    assign Dest_wb     = dest_reg;
    assign Result_WB   = result_reg;
    assign freeze      = hold_v_reg;
    assign ld_busy     = (state_reg == ST_WAIT);

`ifdef WB_SCOREBOARD_EN
    logic        ld_accept;
    logic [15:0] pending_reg, pending_next;

    assign ld_accept = ld_start && ((state_reg == ST_IDLE) || ld_done);

    // A new load to the register just completing keeps its bit set.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pending
            assign pending_next[gi] = (ld_accept && (ld_dest == 4'(gi))) ||
                                      (pending_reg[gi] && !(ld_done && (ld_tag_reg == 4'(gi))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= 16'h0000;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;
`else
    assign pending = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed and random checks of wb_write_arbiter against a queue-based model of the write port.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_en;
    logic [3:0]  alu_dest;
    logic [31:0] alu_result;
    logic        ld_start;
    logic [3:0]  ld_dest;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic        freeze;
    logic        ld_busy;
    logic [15:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_wb_en   (alu_wb_en),
        .alu_dest    (alu_dest),
        .alu_result  (alu_result),
        .ld_start    (ld_start),
        .ld_dest     (ld_dest),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .writeBackEn (writeBackEn),
        .Dest_wb     (Dest_wb),
        .Result_WB   (Result_WB),
        .freeze      (freeze),
        .ld_busy     (ld_busy),
        .pending     (pending)
    );

    // Reference model: a write bus, a queue of deferred ALU results, one in-flight load.
    typedef struct {
        logic [3:0]  d;
        logic [31:0] v;
    } wr_t;

    wr_t         m_hold[$];
    bit          m_busy;
    logic [3:0]  m_tag;
    bit          m_pend[16];
    logic        m_wb;
    logic [3:0]  m_dest;
    logic [31:0] m_res;

    function automatic logic [15:0] exp_pending();
        logic [15:0] p = 16'h0000;
`ifdef WB_SCOREBOARD_EN
        for (int i = 0; i < 16; i++) p[i] = m_pend[i];
`endif
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit  done;
        bit  take_alu;
        wr_t w;
        if (rst) begin
            m_hold.delete();
            m_busy = 0;
            m_tag  = 4'd0;
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
            m_wb   = 1'b0;
            m_dest = 4'd0;
            m_res  = 32'd0;
            return;
        end
        done     = m_busy && mem_ready;
        take_alu = alu_wb_en && (m_hold.size() == 0);
        m_wb     = 1'b0;
        if (done) begin
            m_wb = 1'b1; m_dest = m_tag; m_res = mem_rdata;
            if (take_alu) begin
                w.d = alu_dest; w.v = alu_result;
                m_hold.push_back(w);
            end
        end else if (m_hold.size() != 0) begin
            w = m_hold.pop_front();
            m_wb = 1'b1; m_dest = w.d; m_res = w.v;
        end else if (alu_wb_en) begin
            m_wb = 1'b1; m_dest = alu_dest; m_res = alu_result;
        end
        if (done) m_pend[m_tag] = 0;
        if (ld_start && (!m_busy || done)) begin
            m_pend[ld_dest] = 1;
            m_busy = 1;
            m_tag  = ld_dest;
        end else if (done) begin
            m_busy = 0;
        end
    endtask

    // Drive one cycle of inputs at the negedge, clock, then compare at the next negedge.
    task automatic step(input logic r, input logic ae, input logic [3:0] ad, input logic [31:0] ar,
                        input logic ls, input logic [3:0] ld, input logic mr, input logic [31:0] md);
        rst = r; alu_wb_en = ae; alu_dest = ad; alu_result = ar;
        ld_start = ls; ld_dest = ld; mem_ready = mr; mem_rdata = md;
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("writeBackEn", 32'(writeBackEn), 32'(m_wb));
        chk("Dest_wb", 32'(Dest_wb), 32'(m_dest));
        chk("Result_WB", Result_WB, m_res);
        chk("freeze", 32'(freeze), 32'(m_hold.size() != 0));
        chk("ld_busy", 32'(ld_busy), 32'(m_busy));
        chk("pending", 32'(pending), 32'(exp_pending()));
        $display("t=%0t rst=%b alu=%b R%0d=%h ld=%b R%0d mr=%b %h | we=%b R%0d=%h frz=%b busy=%b pend=%h",
                 $time, r, ae, ad, ar, ls, ld, mr, md,
                 writeBackEn, Dest_wb, Result_WB, freeze, ld_busy, pending);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0);
    endtask

    initial begin
        logic        ls, mr, ae, r;
        logic [15:0] p7, p9;
        p7 = 16'h0000;
        p9 = 16'h0000;
`ifdef WB_SCOREBOARD_EN
        p7 = 16'h0080;
        p9 = 16'h0200;
`endif
        @(negedge clk);
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 4'd9, 32'h1, 1'b1, 4'd9, 1'b1, 32'h2);
        chk("reset_we", 32'(writeBackEn), 32'd0);
        chk("reset_res", Result_WB, 32'd0);
        chk("reset_pend", 32'(pending), 32'd0);

        // ALU only
        step(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 32'd0);
        chk("alu_res", Result_WB, 32'hDEADBEEF);
        chk("alu_frz", 32'(freeze), 32'd0);
        idle();
        chk("alu_once", 32'(writeBackEn), 32'd0);

        // Single load to R7
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 1'b0, 32'd0);
        chk("ld_busy", 32'(ld_busy), 32'd1);
        chk("ld_pend", 32'(pending), 32'(p7));
        idle();
        idle();
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'h12345678);
        chk("ld_dest", 32'(Dest_wb), 32'd7);
        chk("ld_res", Result_WB, 32'h12345678);
        chk("ld_idle", 32'(ld_busy), 32'd0);

        // Collision on R5, ignored mem_ready in IDLE first
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'hBAD0BAD0);
        chk("idle_mr", 32'(writeBackEn), 32'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 1'b0, 32'd0);
        step(1'b0, 1'b1, 4'd5, 32'h5, 1'b0, 4'd0, 1'b1, 32'hAAAA0000);
        chk("col_first", Result_WB, 32'hAAAA0000);
        chk("col_frz", 32'(freeze), 32'd1);
        step(1'b0, 1'b1, 4'd5, 32'h77, 1'b0, 4'd0, 1'b0, 32'd0);
        chk("col_second", Result_WB, 32'h5);
        chk("col_unfrz", 32'(freeze), 32'd0);

        // Back-to-back loads R2 then R9
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b0, 32'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 1'b1, 32'h22222222);
        chk("b2b_dest", 32'(Dest_wb), 32'd2);
        chk("b2b_pend", 32'(pending), 32'(p9));
        chk("b2b_busy", 32'(ld_busy), 32'd1);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'h99999999);
        chk("b2b_r9", 32'(Dest_wb), 32'd9);

        // Reset while in WAIT with a held ALU result
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 1'b0, 32'd0);
        step(1'b0, 1'b1, 4'd15, 32'hF00D, 1'b1, 4'd6, 1'b1, 32'h44444444);
        chk("mid_frz", 32'(freeze), 32'd1);
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0);
        chk("rst_dest", 32'(Dest_wb), 32'd0);
        chk("rst_busy", 32'(ld_busy), 32'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'h66666666);
        chk("rst_nowr", 32'(writeBackEn), 32'd0);

        // Random traffic obeying the issue rule (no ld_start while busy unless completing)
        for (int i = 0; i < 400; i++) begin
            mr = ($urandom_range(0, 2) == 0);
            ls = ($urandom_range(0, 2) == 0) && (!m_busy || mr);
            ae = ($urandom_range(0, 1) == 0);
            r  = ($urandom_range(0, 59) == 0);
            step(r, ae, 4'($urandom_range(0, 15)), $urandom(),
                 ls, 4'($urandom_range(0, 15)), mr, $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
